fma16_flag_collector: RTL and testbench

- Consumer-side endpoint of the fp16 FMA result/flag interface.
- Accepts {result, flags} beats from the FMA special-case/rounding stage over a valid/ready handshake.
- Buffers accepted beats in a small FIFO toward writeback and canonicalizes NaN results.
- Maintains the architectural sticky fflags register and a saturating count of invalid-operation events.

---
 rtl/fma16_flag_collector.sv | 153 +++++++++++++++
 tb/tb_fma16_flag_collector.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fma16_flag_collector.sv
// fma16_flag_collector
//   Consumer-side endpoint of the fp16 FMA result/flag interface. Accepts
//   {result, flags} beats over a valid/ready handshake and queues them in a
//   DEPTH-entry FIFO toward writeback. NaN results are canonicalized when
//   they are pushed. The block also keeps the sticky fflags register and a
//   saturating count of accepted invalid-operation (NV) beats.
//
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   in_valid/in_ready      producer handshake (in_ready = FIFO not full)
//   in_result, in_flags    fp16 result and {NV, OF, UF, NX} flags
//   out_valid/out_ready    writeback handshake for the FIFO head
//   out_result, out_flags  registered FIFO head (NaN-canonicalized result)
//   csr_wr, csr_wdata      fflags write (has priority over csr_clr)
//   csr_clr                clear fflags and nv_count
//   fflags                 sticky accumulated flags
//   nv_count               saturating count of accepted NV beats
module fma16_flag_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_result,
  input  logic [3:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic [3:0]       out_flags,
  input  logic             csr_wr,
  input  logic [3:0]       csr_wdata,
  input  logic             csr_clr,
  output logic [3:0]       fflags,
  output logic [CNT_W-1:0] nv_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]    ZERO_CNT = {CW{1'b0}};
  localparam logic [CNT_W-1:0] NV_MAX   = {CNT_W{1'b1}};

  // Any exponent-all-ones value with a nonzero mantissa is a NaN; all NaNs
  // collapse to the canonical quiet NaN. Infinities and zeros pass through.
  function automatic logic [15:0] canonNan(input logic [15:0] value);
    logic [15:0] result;
    if ((value[14:10] == 5'h1f) && (value[9:0] != 10'h000)) begin
      result = 16'h7e00;
    end else begin
      result = value;
    end
    return result;
  endfunction

  logic [15:0]      memResult [DEPTH];
  logic [3:0]       memFlags  [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    rdPtrNext;
  logic [CW-1:0]    count;
  logic [CW-1:0]    countAfterPop;
  logic [CW-1:0]    countNext;
  logic             push;
  logic             pop;
  logic             nvHit;
  logic [15:0]      pushResult;
  logic [15:0]      headResultNext;
  logic [3:0]       headFlagsNext;
  logic [3:0]       fflagsBase;
  logic [3:0]       fflagsNext;
  logic [CNT_W-1:0] nvNext;

  // Handshake decode, next occupancy, next head value and CSR next-state.
  always_comb begin
    push          = in_valid & in_ready;
    pop           = out_valid & out_ready;
    nvHit         = push & in_flags[3];
    pushResult    = canonNan(in_result);
    rdPtrNext     = rdPtr + AW'(pop);
    countAfterPop = count - CW'(pop);
    countNext     = countAfterPop + CW'(push);

    // The head register always shows the entry at the next read pointer.
    // When the FIFO drains to empty in the same cycle as a push, that entry
    // is the beat being written now, so it comes from the input side.
    headResultNext = out_result;
    headFlagsNext  = out_flags;
    if (countNext == ZERO_CNT) begin
      headResultNext = out_result;
      headFlagsNext  = out_flags;
    end else if (countAfterPop == ZERO_CNT) begin
      headResultNext = pushResult;
      headFlagsNext  = in_flags;
    end else begin
      headResultNext = memResult[rdPtrNext];
      headFlagsNext  = memFlags[rdPtrNext];
    end

    // Write beats clear; flags of a beat pushed this cycle are always OR-ed in.
    if (csr_wr) begin
      fflagsBase = csr_wdata;
    end else if (csr_clr) begin
      fflagsBase = 4'h0;
    end else begin
      fflagsBase = fflags;
    end
    fflagsNext = fflagsBase | (push ? in_flags : 4'h0);

    if (csr_clr) begin
      nvNext = CNT_W'(nvHit);
    end else if (nvHit && (nv_count != NV_MAX)) begin
      nvNext = nv_count + CNT_W'(1'b1);
    end else begin
      nvNext = nv_count;
    end
  end

  // FIFO storage; contents need no reset because only written slots are read.
  always_ff @(posedge clk) begin
    if (push) begin
      memResult[wrPtr] <= pushResult;
      memFlags[wrPtr]  <= in_flags;
    end
  end

  // Pointers, occupancy, registered handshake/head outputs and CSR state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr      <= {AW{1'b0}};
      rdPtr      <= {AW{1'b0}};
      count      <= ZERO_CNT;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= 16'h0000;
      out_flags  <= 4'h0;
      fflags     <= 4'h0;
      nv_count   <= {CNT_W{1'b0}};
    end else begin
      wrPtr      <= wrPtr + AW'(push);
      rdPtr      <= rdPtrNext;
      count      <= countNext;
      in_ready   <= (countNext != FULL_CNT);
      out_valid  <= (countNext != ZERO_CNT);
      out_result <= headResultNext;
      out_flags  <= headFlagsNext;
      fflags     <= fflagsNext;
      nv_count   <= nvNext;
    end
  end

endmodule

// File: tb/tb_fma16_flag_collector.sv
module tb_fma16_flag_collector;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic [15:0] inResult;
  logic [3:0]  inFlags;
  logic        outReady;
  logic        csrWr;
  logic [3:0]  csrWdata;
  logic        csrClr;

  logic        inReadyA, outValidA;
  logic [15:0] outResultA;
  logic [3:0]  outFlagsA, fflagsA;
  logic [7:0]  nvCountA;

  logic        inReadyB, outValidB;
  logic [15:0] outResultB;
  logic [3:0]  outFlagsB, fflagsB;
  logic [1:0]  nvCountB;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [19:0] mq[$];
  logic [3:0]  mFflags;
  int          mNv8;
  int          mNv2;
  bit          lastPush;

  always #5 clk = ~clk;

  fma16_flag_collector #(.DEPTH(DEPTH), .CNT_W(8)) dutA (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReadyA),
    .in_result(inResult), .in_flags(inFlags), .out_valid(outValidA),
    .out_ready(outReady), .out_result(outResultA), .out_flags(outFlagsA),
    .csr_wr(csrWr), .csr_wdata(csrWdata), .csr_clr(csrClr),
    .fflags(fflagsA), .nv_count(nvCountA)
  );

  fma16_flag_collector #(.DEPTH(DEPTH), .CNT_W(2)) dutB (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReadyB),
    .in_result(inResult), .in_flags(inFlags), .out_valid(outValidB),
    .out_ready(outReady), .out_result(outResultB), .out_flags(outFlagsB),
    .csr_wr(csrWr), .csr_wdata(csrWdata), .csr_clr(csrClr),
    .fflags(fflagsB), .nv_count(nvCountB)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // fp16 NaN: biased exponent 31 with a nonzero fraction
  function automatic logic [15:0] refCanon(input logic [15:0] v);
    int expo;
    int frac;
    expo = int'(v[14:10]);
    frac = int'(v[9:0]);
    if (expo == 31 && frac != 0) return 16'h7e00;
    return v;
  endfunction

  task automatic modelClear();
    mq.delete();
    mFflags = 4'h0;
    mNv8 = 0;
    mNv2 = 0;
    lastPush = 1'b0;
  endtask

  task automatic checkAll();
    checkVal("in_ready", 32'(inReadyA), 32'(mq.size() < DEPTH));
    checkVal("out_valid", 32'(outValidA), 32'(mq.size() > 0));
    checkVal("out_valid_b", 32'(outValidB), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      checkVal("out_result", 32'(outResultA), 32'(mq[0][19:4]));
      checkVal("out_flags", 32'(outFlagsA), 32'(mq[0][3:0]));
    end
    checkVal("fflags", 32'(fflagsA), 32'(mFflags));
    checkVal("nv_count8", 32'(nvCountA), 32'(mNv8));
    checkVal("nv_count2", 32'(nvCountB), 32'(mNv2));
  endtask

  // Drive one cycle of inputs (called just after a falling edge), advance the
  // model, then check all outputs at the following falling edge.
  task automatic step(input logic v, input logic [15:0] r, input logic [3:0] f,
                      input logic ordy, input logic wr, input logic [3:0] wd,
                      input logic clr);
    bit doPush;
    bit doPop;
    logic [3:0] base;
    inValid = v; inResult = r; inFlags = f; outReady = ordy;
    csrWr = wr; csrWdata = wd; csrClr = clr;
    doPush = v && (mq.size() < DEPTH);
    doPop  = ordy && (mq.size() > 0);
    base = wr ? wd : (clr ? 4'h0 : mFflags);
    mFflags = base | (doPush ? f : 4'h0);
    if (clr) begin
      mNv8 = 0;
      mNv2 = 0;
    end
    if (doPush && f[3]) begin
      if (mNv8 < 255) mNv8++;
      if (mNv2 < 3) mNv2++;
    end
    if (doPop) void'(mq.pop_front());
    if (doPush) mq.push_back({refCanon(r), f});
    lastPush = doPush;
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    logic [15:0] hr;
    logic [3:0]  hf;
    bit          hv;
    reset = 1'b1;
    inValid = 1'b0; inResult = 16'h0000; inFlags = 4'h0; outReady = 1'b0;
    csrWr = 1'b0; csrWdata = 4'h0; csrClr = 1'b0;
    modelClear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkAll();
    checkVal("reset_result", 32'(outResultA), 32'h0000);

    // single beat
    step(1'b1, 16'h3c00, 4'b0001, 1'b0, 1'b0, 4'h0, 1'b0);
    checkVal("single_valid", 32'(outValidA), 32'd1);
    checkVal("single_result", 32'(outResultA), 32'h3c00);
    checkVal("single_fflags", 32'(fflagsA), 32'h1);
    step(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0);
    checkVal("single_pop", 32'(outValidA), 32'd0);

    // NaN canonicalization and counter
    step(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b1, 16'h7c01, 4'b1000, 1'b0, 1'b0, 4'h0, 1'b0);
    checkVal("nan1", 32'(outResultA), 32'h7e00);
    step(1'b1, 16'hfe55, 4'b1000, 1'b1, 1'b0, 4'h0, 1'b0);
    checkVal("nan2", 32'(outResultA), 32'h7e00);
    checkVal("nan_fflags", 32'(fflagsA), 32'h8);
    checkVal("nan_cnt", 32'(nvCountA), 32'd2);
    step(1'b1, 16'h7c00, 4'b0000, 1'b1, 1'b0, 4'h0, 1'b0);
    checkVal("inf", 32'(outResultA), 32'h7c00);
    step(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0);

    // fill and backpressure
    for (int i = 0; i < 4; i++) step(1'b1, 16'h4000 + 16'(i), 4'h2, 1'b0, 1'b0, 4'h0, 1'b0);
    checkVal("full_ready", 32'(inReadyA), 32'd0);
    step(1'b1, 16'h4444, 4'h4, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 16'h4444, 4'h4, 1'b1, 1'b0, 4'h0, 1'b0);
    checkVal("ready_after_pop", 32'(inReadyA), 32'd1);
    step(1'b1, 16'h4444, 4'h4, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0);

    // CSR races
    step(1'b0, 16'h0000, 4'h0, 1'b1, 1'b1, 4'b0110, 1'b0);
    step(1'b1, 16'h3800, 4'b0001, 1'b1, 1'b0, 4'h0, 1'b1);
    checkVal("race_clr", 32'(fflagsA), 32'h1);
    step(1'b1, 16'h3800, 4'b0100, 1'b1, 1'b1, 4'b1000, 1'b1);
    checkVal("race_wr", 32'(fflagsA), 32'hc);

    // saturation
    step(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h7d00, 4'b1000, 1'b1, 1'b0, 4'h0, 1'b0);
    checkVal("sat2", 32'(nvCountB), 32'd3);
    checkVal("sat8", 32'(nvCountA), 32'd5);
    step(1'b1, 16'h7d00, 4'b1000, 1'b1, 1'b0, 4'h0, 1'b1);
    checkVal("clr_push2", 32'(nvCountB), 32'd1);
    checkVal("clr_push8", 32'(nvCountA), 32'd1);
    step(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0);

    // asynchronous reset with two entries queued
    step(1'b1, 16'h1234, 4'b1010, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 16'h5678, 4'b0101, 1'b0, 1'b0, 4'h0, 1'b0);
    inValid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkVal("rst_valid", 32'(outValidA), 32'd0);
    checkVal("rst_result", 32'(outResultA), 32'h0000);
    checkVal("rst_flags", 32'(outFlagsA), 32'h0);
    checkVal("rst_fflags", 32'(fflagsA), 32'h0);
    checkVal("rst_nv", 32'(nvCountA), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    modelClear();
    #1;
    checkVal("rst_ready", 32'(inReadyA), 32'd1);
    @(negedge clk);
    checkAll();

    // randomized traffic; a beat not accepted is held stable
    hv = 1'b0; hr = 16'h0000; hf = 4'h0;
    for (int n = 0; n < 400; n++) begin
      logic [15:0] r;
      logic [3:0]  f;
      logic        v;
      if (hv && !lastPush) begin
        v = 1'b1; r = hr; f = hf;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0: r = 16'h7c00 | 16'($urandom_range(0, 1023)) | (16'($urandom_range(0, 1)) << 15);
          1: r = 16'h7c00;
          default: r = 16'($urandom);
        endcase
        f = 4'($urandom);
      end
      step(v, r, f, ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 15) == 0), 4'($urandom),
           ($urandom_range(0, 15) == 0));
      hv = v; hr = r; hf = f;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
